// File: rtl/spi_xfer_ctrl.sv
// Sequencer for one SPI byte exchange: clears sender/receiver, loads the TX byte,
// opens the TE/RE bit window, waits for the receiver to fill and captures the RX byte.
module spi_xfer_ctrl #(
   parameter int DATA_W     = 8,
   parameter int XFER_EXTRA = 0,
   parameter int TIMEOUT    = 16
) (
   input  logic              clk_i,
   input  logic              clr_n_i,
   input  logic              start_i,
   input  logic              no_rx_i,
   input  logic [DATA_W-1:0] tx_data_i,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [DATA_W-1:0] s_data_o,
   output logic              s_clr_o,
   output logic              s_write_o,
   output logic              s_te_o,
   output logic              r_clr_o,
   output logic              r_re_o,
   output logic              r_read_o,
   input  logic              r_full_i,
   input  logic [DATA_W-1:0] r_data_i
);

   localparam int XFER_LEN = DATA_W + XFER_EXTRA;
   localparam int CNT_MAX  = (XFER_LEN > TIMEOUT) ? XFER_LEN : TIMEOUT;
   localparam int CNT_W    = $clog2(CNT_MAX) + 1;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_LOAD,
      ST_XFER,
      ST_WAIT_FULL,
      ST_READ,
      ST_CAPT,
      ST_ERROR,
      ST_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic              no_rx_q, no_rx_d;
   logic              err_q, err_d;

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk_i or negedge clr_n_i) begin
      if (!clr_n_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         no_rx_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         no_rx_q <= no_rx_d;
         err_q   <= err_d;
      end
   end

   // NOTE: every variable gets its hold value before the case so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      no_rx_d = no_rx_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               tx_d    = tx_data_i;
               no_rx_d = no_rx_i;
               err_d   = 1'b0;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: state_d = ST_LOAD;
         ST_LOAD: begin
            cnt_d   = CNT_W'(XFER_LEN - 1);
            state_d = ST_XFER;
         end
         ST_XFER: begin
            if (cnt_q == '0) begin
               if (no_rx_q) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_d   = CNT_W'(TIMEOUT - 1);
                  state_d = ST_WAIT_FULL;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_WAIT_FULL: begin
            if (r_full_i) begin
               state_d = ST_READ;
            end else if (cnt_q == '0) begin
               state_d = ST_ERROR;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_READ: state_d = ST_CAPT;
         ST_CAPT: begin
            rx_d    = r_data_i;
            state_d = ST_DONE;
         end
         ST_ERROR: begin
            err_d   = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Strobes are pure state decodes, so an async reset drops them at once.
   assign s_clr_o   = (state_q == ST_CLEAR);
   assign r_clr_o   = (state_q == ST_CLEAR);
   assign s_write_o = (state_q == ST_LOAD);
   assign s_te_o    = (state_q == ST_XFER);
   assign r_re_o    = (state_q == ST_XFER) && !no_rx_q;
   assign r_read_o  = (state_q == ST_READ);
   assign done_o    = (state_q == ST_DONE);
   assign busy_o    = (state_q != ST_IDLE);
   assign err_o     = err_q;
   assign rx_data_o = rx_q;
   assign s_data_o  = tx_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: two instances (XFER_EXTRA 0 and 2) driven in lockstep,
// each attached to a bit-serial MOSI->MISO loopback sender/receiver model.
module tb_spi_xfer_ctrl;

   localparam int DW     = 8;
   localparam int TO     = 16;
   localparam int EXTRA1 = 2;

   logic clk = 1'b0;
   logic clr_n = 1'b0;
   logic start = 1'b0;
   logic no_rx = 1'b0;
   logic [DW-1:0] tx_data = '0;
   bit full_en = 1'b1;

   logic [DW-1:0] rx_data[2];
   logic [DW-1:0] s_data[2];
   logic [DW-1:0] r_data[2];
   logic busy[2], done[2], err[2];
   logic s_clr[2], s_write[2], s_te[2], r_clr[2], r_re[2], r_read[2], r_full[2];

   always #5 clk = ~clk;

   spi_xfer_ctrl #(.DATA_W(DW), .XFER_EXTRA(0), .TIMEOUT(TO)) u_dut0 (
      .clk_i(clk), .clr_n_i(clr_n), .start_i(start), .no_rx_i(no_rx), .tx_data_i(tx_data),
      .rx_data_o(rx_data[0]), .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]),
      .s_data_o(s_data[0]), .s_clr_o(s_clr[0]), .s_write_o(s_write[0]), .s_te_o(s_te[0]),
      .r_clr_o(r_clr[0]), .r_re_o(r_re[0]), .r_read_o(r_read[0]),
      .r_full_i(r_full[0]), .r_data_i(r_data[0]));

   spi_xfer_ctrl #(.DATA_W(DW), .XFER_EXTRA(EXTRA1), .TIMEOUT(TO)) u_dut1 (
      .clk_i(clk), .clr_n_i(clr_n), .start_i(start), .no_rx_i(no_rx), .tx_data_i(tx_data),
      .rx_data_o(rx_data[1]), .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]),
      .s_data_o(s_data[1]), .s_clr_o(s_clr[1]), .s_write_o(s_write[1]), .s_te_o(s_te[1]),
      .r_clr_o(r_clr[1]), .r_re_o(r_re[1]), .r_read_o(r_read[1]),
      .r_full_i(r_full[1]), .r_data_i(r_data[1]));

   // Loopback peripheral: sender shifts MSB first, receiver takes DW bits then reports full.
   logic [DW-1:0] tx_sh[2] = '{8'h00, 8'h00};
   logic [DW-1:0] rx_sh[2] = '{8'h00, 8'h00};
   int            rx_cnt[2] = '{0, 0};

   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (s_clr[g])        tx_sh[g] <= '0;
         else if (s_write[g]) tx_sh[g] <= s_data[g];
         else if (s_te[g])    tx_sh[g] <= tx_sh[g] << 1;
         if (r_clr[g]) begin
            rx_sh[g]  <= '0;
            rx_cnt[g] <= 0;
         end else if (r_re[g] && rx_cnt[g] < DW) begin
            rx_sh[g]  <= {rx_sh[g][DW-2:0], tx_sh[g][DW-1]};
            rx_cnt[g] <= rx_cnt[g] + 1;
         end
      end
   end

   always_comb begin
      for (int g = 0; g < 2; g++) begin
         r_full[g] = full_en && (rx_cnt[g] >= DW);
         r_data[g] = rx_sh[g];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Per-transfer activity counters, sampled mid-cycle.
   int   n_clr[2], n_write[2], n_te[2], te_rise[2], n_re[2], n_read[2];
   int   n_done[2], n_busy[2], viol[2], clr_cyc[2], done_cyc[2];
   logic te_prev[2] = '{1'b0, 1'b0};

   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (s_clr[g]) begin
            n_clr[g]++;
            clr_cyc[g] = cyc;
         end
         if (s_clr[g] !== r_clr[g]) viol[g]++;
         if (r_re[g] && !s_te[g]) viol[g]++;
         if ($countones({s_clr[g], s_write[g], s_te[g], r_read[g], done[g]}) > 1) viol[g]++;
         if (s_write[g]) n_write[g]++;
         if (s_te[g]) begin
            n_te[g]++;
            if (!te_prev[g]) te_rise[g]++;
         end
         te_prev[g] = s_te[g];
         if (r_re[g])   n_re[g]++;
         if (r_read[g]) n_read[g]++;
         if (busy[g])   n_busy[g]++;
         if (done[g]) begin
            n_done[g]++;
            done_cyc[g] = cyc;
         end
      end
   end

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] rx_exp[2] = '{8'h00, 8'h00};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int xfer_len(input int g);
      return (g == 0) ? DW : DW + EXTRA1;
   endfunction

   // Cycles from the START-sampling edge to DONE: CLEAR, LOAD, n XFER, then
   // either DONE, or WAIT(1)/READ/CAPT/DONE, or WAIT(TO)/ERROR/DONE.
   function automatic int exp_latency(input int n, input bit nrx, input bit fok);
      if (nrx) return n + 3;
      if (fok) return n + 6;
      return n + 4 + TO;
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_mon();
      for (int g = 0; g < 2; g++) begin
         n_clr[g] = 0; n_write[g] = 0; n_te[g] = 0; te_rise[g] = 0; n_re[g] = 0;
         n_read[g] = 0; n_done[g] = 0; n_busy[g] = 0; viol[g] = 0;
         clr_cyc[g] = -1; done_cyc[g] = -1;
      end
   endtask

   task automatic run_xfer(input logic [DW-1:0] tx, input bit nrx, input bit fok);
      int s_cyc;
      int budget;
      int n;
      tick();
      full_en = fok;
      clear_mon();
      tx_data = tx;
      no_rx   = nrx;
      start   = 1'b1;
      s_cyc   = cyc;
      tick();
      start = 1'b0;
      budget = 0;
      while ((n_done[0] == 0 || n_done[1] == 0) && budget < 80) begin
         tick();
         budget++;
      end
      check("done_timeout", 32'(budget < 80), 1);
      for (int g = 0; g < 2; g++) begin
         n = xfer_len(g);
         check($sformatf("latency[%0d] tx=%0h", g, tx), done_cyc[g] - s_cyc, exp_latency(n, nrx, fok));
         check($sformatf("clr_at[%0d]", g), clr_cyc[g] - s_cyc, 1);
         check($sformatf("busy_cycles[%0d]", g), n_busy[g], exp_latency(n, nrx, fok));
         check($sformatf("n_clr[%0d]", g), n_clr[g], 1);
         check($sformatf("n_write[%0d]", g), n_write[g], 1);
         check($sformatf("n_te[%0d]", g), n_te[g], n);
         check($sformatf("te_rise[%0d]", g), te_rise[g], 1);
         check($sformatf("n_re[%0d]", g), n_re[g], nrx ? 0 : n);
         check($sformatf("n_read[%0d]", g), n_read[g], (nrx || !fok) ? 0 : 1);
         check($sformatf("n_done[%0d]", g), n_done[g], 1);
         check($sformatf("strobe_viol[%0d]", g), viol[g], 0);
         check($sformatf("err[%0d]", g), 32'(err[g]), 32'(!nrx && !fok));
         if (!nrx && fok) rx_exp[g] = tx;
         check($sformatf("rx_data[%0d]", g), 32'(rx_data[g]), 32'(rx_exp[g]));
         check($sformatf("s_data[%0d]", g), 32'(s_data[g]), 32'(tx));
      end
   endtask

   initial begin
      int s_cyc;
      int budget;
      clear_mon();

      // Reset state.
      repeat (3) tick();
      for (int g = 0; g < 2; g++) begin
         check($sformatf("rst_outs[%0d]", g),
               32'({busy[g], done[g], err[g], s_clr[g], s_write[g], s_te[g], r_clr[g], r_re[g], r_read[g]}), 0);
         check($sformatf("rst_rx[%0d]", g), 32'(rx_data[g]), 0);
         check($sformatf("rst_sdata[%0d]", g), 32'(s_data[g]), 0);
      end
      clr_n = 1'b1;
      repeat (2) tick();

      // Loopback, transmit-only, then receiver that never fills.
      run_xfer(8'h62, 1'b0, 1'b1);
      run_xfer(8'hA5, 1'b1, 1'b1);
      run_xfer(8'h81, 1'b0, 1'b0);
      repeat (3) tick();
      for (int g = 0; g < 2; g++) check($sformatf("err_held[%0d]", g), 32'(err[g]), 1);
      run_xfer(8'h62, 1'b0, 1'b1);

      // START held high across a whole transfer: restart right after DONE.
      tick();
      full_en = 1'b1;
      clear_mon();
      tx_data = 8'hC3;
      no_rx   = 1'b0;
      start   = 1'b1;
      s_cyc   = cyc;
      budget  = 0;
      while ((n_clr[0] < 2 || n_clr[1] < 2) && budget < 80) begin
         tick();
         budget++;
      end
      start = 1'b0;
      check("hold_timeout", 32'(budget < 80), 1);
      for (int g = 0; g < 2; g++) begin
         check($sformatf("hold_first_lat[%0d]", g), done_cyc[g] - s_cyc, exp_latency(xfer_len(g), 1'b0, 1'b1));
         check($sformatf("hold_restart[%0d]", g), clr_cyc[g] - done_cyc[g], 2);
         check($sformatf("hold_n_done[%0d]", g), n_done[g], 1);
      end
      budget = 0;
      while ((n_done[0] < 2 || n_done[1] < 2) && budget < 80) begin
         tick();
         budget++;
      end
      check("hold2_timeout", 32'(budget < 80), 1);
      for (int g = 0; g < 2; g++) begin
         rx_exp[g] = 8'hC3;
         check($sformatf("hold2_lat[%0d]", g), done_cyc[g] - clr_cyc[g], exp_latency(xfer_len(g), 1'b0, 1'b1) - 1);
         check($sformatf("hold2_n_clr[%0d]", g), n_clr[g], 2);
         check($sformatf("hold2_rx[%0d]", g), 32'(rx_data[g]), 32'(rx_exp[g]));
         check($sformatf("hold2_viol[%0d]", g), viol[g], 0);
      end

      // Asynchronous reset in the fifth XFER cycle.
      tick();
      clear_mon();
      tx_data = 8'h5A;
      no_rx   = 1'b0;
      start   = 1'b1;
      s_cyc   = cyc;
      tick();
      start = 1'b0;
      while (cyc < s_cyc + 7) tick();
      check("pre_rst_te", 32'({s_te[0], s_te[1]}), 32'h3);
      #2 clr_n = 1'b0;
      #1;
      for (int g = 0; g < 2; g++) begin
         check($sformatf("midrst_outs[%0d]", g),
               32'({busy[g], done[g], err[g], s_clr[g], s_write[g], s_te[g], r_clr[g], r_re[g], r_read[g]}), 0);
         check($sformatf("midrst_rx[%0d]", g), 32'(rx_data[g]), 0);
         rx_exp[g] = '0;
      end
      tick();
      clear_mon();
      clr_n = 1'b1;
      repeat (20) tick();
      for (int g = 0; g < 2; g++) begin
         check($sformatf("post_rst_done[%0d]", g), n_done[g], 0);
         check($sformatf("post_rst_busy[%0d]", g), n_busy[g], 0);
      end
      run_xfer(8'h3C, 1'b0, 1'b1);

      // Randomized transfers.
      for (int i = 0; i < 10; i++) begin
         run_xfer(DW'($urandom), ($urandom_range(3) == 0), ($urandom_range(4) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
